// File: rtl/mem_region_pkg.sv
// mem_region_pkg: shared types and constants for the data-port memory controller
package mem_region_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t DONE   = 2'd2;
    typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM} region_t;
    typedef enum logic [1:0] {ERR_OK, ERR_UNMAPPED, ERR_ROM_WR, ERR_MISALIGNED} err_t;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/mem_region_decoder.sv
// region_decoder: maps one byte address onto the ROM/RAM windows with rebased offset and error code
module region_decoder
    import mem_region_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int ROM_BASE = 400,
    parameter int ROM_SIZE = 8100,
    parameter int RAM_BASE = 8500,
    parameter int RAM_SIZE = 129600
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              we,
    output region_t           region,
    output logic [ADDR_W-1:0] offset,
    output err_t              err
);
    localparam logic [ADDR_W-1:0] ROM_LO = ADDR_W'(ROM_BASE);
    localparam logic [ADDR_W-1:0] ROM_HI = ADDR_W'(ROM_BASE + ROM_SIZE);
    localparam logic [ADDR_W-1:0] RAM_LO = ADDR_W'(RAM_BASE);
    localparam logic [ADDR_W-1:0] RAM_HI = ADDR_W'(RAM_BASE + RAM_SIZE);
    logic in_rom, in_ram;
    assign in_rom = address >= ROM_LO && address < ROM_HI;
    assign in_ram = address >= RAM_LO && address < RAM_HI;
    assign region = in_rom ? REG_ROM : in_ram ? REG_RAM : REG_NONE;
    assign offset = in_rom ? address - ROM_LO : in_ram ? address - RAM_LO : '0;
    assign err = |address[1:0] ? ERR_MISALIGNED :
                 !(in_rom || in_ram) ? ERR_UNMAPPED :
                 (in_rom && we) ? ERR_ROM_WR : ERR_OK;
endmodule

// File: rtl/mem_region_ctrl.sv
// mem_region_ctrl: handshaked ROM/RAM data-port controller with per-region wait states and error responses
module mem_region_ctrl
    import mem_region_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ROM_BASE = 400,
    parameter int ROM_SIZE = 8100,
    parameter int RAM_BASE = 8500,
    parameter int RAM_SIZE = 129600,
    parameter int ROM_WAIT = 0,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wd,
    output logic              ready,
    output logic              busy,
    output logic              rvalid,
    output logic [DATA_W-1:0] rd,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd
);
    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic              we_l;
    logic [DATA_W-1:0] wd_l;
    region_t           reg_l;
    logic [ADDR_W-1:0] off_l;
    err_t              code_l;
    region_t           dec_region;
    logic [ADDR_W-1:0] dec_off;
    err_t              dec_err;
    logic              last;

    region_decoder #(
        .ADDR_W(ADDR_W), .ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE),
        .RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE)
    ) u_dec (
        .address(address), .we(we), .region(dec_region), .offset(dec_off), .err(dec_err)
    );

    assign ready    = state == IDLE;
    assign busy     = ~ready;
    assign rvalid   = state == DONE;
    assign last     = state == ACCESS && cnt == '0;
    assign err      = code_l != ERR_OK;
    assign err_code = code_l;
    assign rom_addr = reg_l == REG_ROM ? off_l : '0;
    assign ram_addr = reg_l == REG_RAM ? off_l : '0;
    // Combinational strobe so an async reset drops it within the same cycle
    assign ram_we   = last && reg_l == REG_RAM && we_l;
    assign ram_wd   = wd_l;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            we_l   <= 1'b0;
            wd_l   <= '0;
            reg_l  <= REG_NONE;
            off_l  <= '0;
            code_l <= ERR_OK;
            rd     <= '0;
        end else if (state == IDLE) begin
            if (req) begin
                we_l   <= we;
                wd_l   <= wd;
                code_l <= dec_err;
                rd     <= '0;
                // Erroring requests never select a memory, so neither port sees them
                reg_l  <= dec_err == ERR_OK ? dec_region : REG_NONE;
                off_l  <= dec_err == ERR_OK ? dec_off : '0;
                cnt    <= dec_region == REG_RAM ? WAIT_W'(RAM_WAIT) : WAIT_W'(ROM_WAIT);
                state  <= dec_err == ERR_OK ? ACCESS : DONE;
            end
        end else if (state == ACCESS) begin
            cnt <= cnt - 1'b1;
            if (last) begin
                rd    <= we_l ? '0 : reg_l == REG_RAM ? ram_rd : rom_rd;
                state <= DONE;
            end
        end else
            state <= IDLE;
endmodule
